// File: rtl/message_reader_pkg.sv
// rtl/message_reader_pkg.sv - shared FSM encoding and default widths for the message reader
package message_reader_pkg;

  // Playback sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_PRESENT = 3'd2,
    ST_GAP     = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  localparam int CHAR_W_DEF  = 4;
  localparam int IDX_W_DEF   = 4;
  localparam int DWELL_W_DEF = 8;

endpackage

// File: rtl/message_reader_dwell_timer.sv
// rtl/message_reader_dwell_timer.sv - load/count-down dwell counter with zero flag
module message_reader_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_load_val,
  input  logic               i_dec,
  output logic               o_zero
);

  localparam logic [DWELL_W-1:0] ONE_CNT = 1;

  logic [DWELL_W-1:0] r_count;

  // Load takes precedence; counting stops at zero so the flag holds
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - ONE_CNT;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/message_reader.sv
// rtl/message_reader.sv - ROM index sequencer streaming a message over valid/ready
module message_reader
  import message_reader_pkg::*;
#(
  parameter int CHAR_W  = CHAR_W_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_repeat_en,
  input  logic               i_abort,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [CHAR_W-1:0]  i_caracter,
  input  logic [IDX_W-1:0]   i_len_string,
  output logic [IDX_W-1:0]   o_counter_caracter,
  output logic [CHAR_W-1:0]  o_char_out,
  output logic               o_char_valid,
  input  logic               i_char_ready,
  output logic               o_first,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [IDX_W-1:0]   ONE_IDX   = 1;
  localparam logic [DWELL_W-1:0] ONE_DWELL = 1;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_len;
  logic [DWELL_W-1:0]  r_dwell;
  logic                r_repeat;
  logic [CHAR_W-1:0]   r_char_out;
  logic                r_char_valid;
  logic                r_first;
  logic                r_last;
  logic                r_busy;
  logic                r_done;

  logic                w_handshake;
  logic                w_more_chars;
  logic                w_gap_load;
  logic                w_gap_dec;
  logic                w_gap_zero;

  // Valid is only ever high in PRESENT, so this is the accept event
  assign w_handshake  = r_char_valid && i_char_ready;
  // After an accepted char playback continues unless it was the final char of a single pass
  assign w_more_chars = !r_last || r_repeat;
  // Timer holds dwell-1 so that GAP lasts exactly dwell cycles before leaving on zero
  assign w_gap_load   = (r_state == ST_PRESENT) && w_handshake && !i_abort &&
                        w_more_chars && (r_dwell != '0);
  assign w_gap_dec    = (r_state == ST_GAP) && !i_abort;

  message_reader_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_gap_load),
    .i_load_val (r_dwell - ONE_DWELL),
    .i_dec      (w_gap_dec),
    .o_zero     (w_gap_zero)
  );

  // Playback FSM with index register and registered consumer-side outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_len        <= '0;
      r_dwell      <= '0;
      r_repeat     <= 1'b0;
      r_char_out   <= '0;
      r_char_valid <= 1'b0;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // done is a single-cycle pulse raised only on entry to FINISH
      r_done <= 1'b0;
      if ((r_state != ST_IDLE) && i_abort) begin
        r_state      <= ST_IDLE;
        r_char_valid <= 1'b0;
        r_busy       <= 1'b0;
        r_idx        <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              r_len    <= i_len_string;
              r_dwell  <= i_dwell;
              r_repeat <= i_repeat_en;
              r_idx    <= '0;
              r_busy   <= 1'b1;
              if (i_len_string == '0) begin
                r_state <= ST_FINISH;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_FETCH;
              end
            end
          end

          ST_FETCH: begin
            // ROM is combinational on the registered index, so its data is ready here
            r_char_out   <= i_caracter;
            r_first      <= (r_idx == '0);
            r_last       <= (r_idx == (r_len - ONE_IDX));
            r_char_valid <= 1'b1;
            r_state      <= ST_PRESENT;
          end

          ST_PRESENT: begin
            if (w_handshake) begin
              r_char_valid <= 1'b0;
              if (!w_more_chars) begin
                r_state <= ST_FINISH;
                r_done  <= 1'b1;
              end else begin
                r_idx   <= r_last ? '0 : (r_idx + ONE_IDX);
                r_state <= (r_dwell != '0) ? ST_GAP : ST_FETCH;
              end
            end
          end

          ST_GAP: begin
            if (w_gap_zero) begin
              r_state <= ST_FETCH;
            end
          end

          ST_FINISH: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end

          default: begin
            r_state      <= ST_IDLE;
            r_char_valid <= 1'b0;
            r_busy       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_counter_caracter = r_idx;
  assign o_char_out         = r_char_out;
  assign o_char_valid       = r_char_valid;
  assign o_first            = r_first;
  assign o_last             = r_last;
  assign o_busy             = r_busy;
  assign o_done             = r_done;

endmodule

// File: tb/tb_message_reader.sv
// tb/tb_message_reader.sv - self-checking bench for message_reader
module tb_message_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       repeat_en = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic [3:0] caracter;
  logic [3:0] len_string = 4'd5;
  logic [3:0] counter_caracter;
  logic [3:0] char_out;
  logic       char_valid;
  logic       char_ready = 1'b0;
  logic       first;
  logic       last;
  logic       busy;
  logic       done;

  logic [3:0] rom [0:15];
  logic [3:0] base [0:4] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd10};

  assign caracter = rom[counter_caracter];

  message_reader dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_start            (start),
    .i_repeat_en        (repeat_en),
    .i_abort            (abort),
    .i_dwell            (dwell),
    .i_caracter         (caracter),
    .i_len_string       (len_string),
    .o_counter_caracter (counter_caracter),
    .o_char_out         (char_out),
    .o_char_valid       (char_valid),
    .i_char_ready       (char_ready),
    .o_first            (first),
    .o_last             (last),
    .o_busy             (busy),
    .o_done             (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       st;
    logic       rdy;
    logic       ab;
    logic [3:0] ln;
    logic       v;
    logic [3:0] ch;
    logic       f;
    logic       l;
    logic       b;
    logic       d;
    logic       ci;
    logic [3:0] ix;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic st, input logic rdy, input logic ab, input logic [3:0] ln,
                              input logic v, input logic [3:0] ch, input logic f, input logic l,
                              input logic b, input logic d, input logic ci, input logic [3:0] ix);
    vec_t x;
    x.st = st; x.rdy = rdy; x.ab = ab; x.ln = ln; x.v = v; x.ch = ch;
    x.f = f; x.l = l; x.b = b; x.d = d; x.ci = ci; x.ix = ix;
    return x;
  endfunction

  task automatic load_base_rom();
    for (int i = 0; i < 16; i++) rom[i] = 4'd15;
    for (int i = 0; i < 5; i++) rom[i] = base[i];
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".valid"}, char_valid, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".idx"}, counter_caracter, 0);
    chk({tag, ".char"}, char_out, 0);
    chk({tag, ".first"}, first, 0);
    chk({tag, ".last"}, last, 0);
  endtask

  // Randomized pass checked against the rule-level model: the k-th accepted char is
  // rom[k mod len], the next char rises dwell+2 cycles after an accept, and data holds while stalled
  task automatic run_random(input int r);
    int len, dw, k, target, last_hs, dones, e;
    bit rep, fin, prev_v, prev_r, hs;
    logic [3:0] pch;
    logic pf, pl;
    len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
    dw  = $urandom_range(0, 3);
    rep = 1'($urandom_range(0, 1));
    for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
    len_string = 4'(len); dwell = 8'(dw); repeat_en = rep;
    start = 1'b1; char_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    len_string = 4'($urandom_range(0, 15));
    target = (rep && len != 0) ? 2 * len + 2 : len;
    k = 0; last_hs = 0; dones = 0; fin = 0; prev_v = 0; prev_r = 0;
    pch = '0; pf = 0; pl = 0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      abort = 1'b0;
      if (!busy) begin
        fin = 1;
      end else begin
        if (done) dones++;
        if (char_valid) begin
          if (prev_v && !prev_r) begin
            chk($sformatf("rnd%0d.stall_char", r), char_out, pch);
            chk($sformatf("rnd%0d.stall_first", r), first, pf);
            chk($sformatf("rnd%0d.stall_last", r), last, pl);
          end else if (!prev_v && k == 0) begin
            chk($sformatf("rnd%0d.latency", r), cyc, 1);
          end else if (!prev_v) begin
            chk($sformatf("rnd%0d.gap", r), cyc - last_hs, dw + 2);
          end
        end
        char_ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 7) == 0);
        hs = char_valid && char_ready;
        if (rep && len != 0 && k == target) begin
          abort = 1'b1; char_ready = 1'b0; start = 1'b0; hs = 0;
        end
        if (hs) begin
          e = k % len;
          chk($sformatf("rnd%0d.char%0d", r, k), char_out, rom[e]);
          chk($sformatf("rnd%0d.first%0d", r, k), first, (e == 0));
          chk($sformatf("rnd%0d.last%0d", r, k), last, (e == len - 1));
          k++;
          last_hs = cyc;
        end
        prev_v = char_valid; prev_r = char_ready;
        pch = char_out; pf = first; pl = last;
        @(posedge clk); @(negedge clk);
      end
    end
    abort = 1'b0; start = 1'b0; char_ready = 1'b0;
    chk($sformatf("rnd%0d.ended", r), fin, 1);
    chk($sformatf("rnd%0d.accepts", r), k, target);
    chk($sformatf("rnd%0d.dones", r), dones, (rep && len != 0) ? 0 : 1);
  endtask

  initial begin
    int k, inv, dn;
    bit seen;
    load_base_rom();

    // Reset state
    #2;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Single-shot pass, empty message, abort then replay
    //           st rdy ab len  v  ch  f  l  b  d  ci ix
    vt.push_back(mk(1, 1, 0, 5, 0, 0,  0, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 5, 1, 0,  1, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 5, 0, 0,  0, 0, 1, 0, 1, 1));
    vt.push_back(mk(0, 1, 0, 5, 1, 1,  0, 0, 1, 0, 1, 1));
    vt.push_back(mk(0, 1, 0, 5, 0, 0,  0, 0, 1, 0, 1, 2));
    vt.push_back(mk(0, 1, 0, 5, 1, 3,  0, 0, 1, 0, 1, 2));
    vt.push_back(mk(0, 1, 0, 5, 0, 0,  0, 0, 1, 0, 1, 3));
    vt.push_back(mk(0, 1, 0, 5, 1, 4,  0, 0, 1, 0, 1, 3));
    vt.push_back(mk(0, 1, 0, 5, 0, 0,  0, 0, 1, 0, 1, 4));
    vt.push_back(mk(0, 1, 0, 5, 1, 10, 0, 1, 1, 0, 1, 4));
    vt.push_back(mk(0, 1, 0, 5, 0, 0,  0, 0, 1, 1, 0, 0));
    vt.push_back(mk(0, 1, 0, 5, 0, 0,  0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 5, 0, 0,  0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0, 1, 1, 1, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 0, 5, 0, 0,  0, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 5, 1, 0,  1, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 5, 0, 0,  0, 0, 1, 0, 1, 1));
    vt.push_back(mk(0, 1, 0, 5, 1, 1,  0, 0, 1, 0, 1, 1));
    vt.push_back(mk(0, 1, 0, 5, 0, 0,  0, 0, 1, 0, 1, 2));
    vt.push_back(mk(0, 1, 0, 5, 1, 3,  0, 0, 1, 0, 1, 2));
    vt.push_back(mk(0, 1, 0, 5, 0, 0,  0, 0, 1, 0, 1, 3));
    vt.push_back(mk(0, 1, 0, 5, 1, 4,  0, 0, 1, 0, 1, 3));
    vt.push_back(mk(0, 1, 1, 5, 0, 0,  0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 5, 0, 0,  0, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 5, 0, 0,  0, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 5, 1, 0,  1, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 0, 1, 5, 0, 0,  0, 0, 0, 0, 1, 0));

    repeat_en = 1'b0; dwell = 8'd0;
    for (int i = 0; i < vt.size(); i++) begin
      start = vt[i].st; char_ready = vt[i].rdy; abort = vt[i].ab; len_string = vt[i].ln;
      @(posedge clk); @(negedge clk);
      chk($sformatf("tbl%0d.valid", i), char_valid, vt[i].v);
      chk($sformatf("tbl%0d.busy", i), busy, vt[i].b);
      chk($sformatf("tbl%0d.done", i), done, vt[i].d);
      if (vt[i].v) begin
        chk($sformatf("tbl%0d.char", i), char_out, vt[i].ch);
        chk($sformatf("tbl%0d.first", i), first, vt[i].f);
        chk($sformatf("tbl%0d.last", i), last, vt[i].l);
      end
      if (vt[i].ci) chk($sformatf("tbl%0d.idx", i), counter_caracter, vt[i].ix);
    end
    start = 1'b0; abort = 1'b0; char_ready = 1'b0;

    // Back-pressure on index 2, with an ignored start while stalled
    len_string = 4'd5; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      if (char_valid && counter_caracter == 4'd2) begin
        char_ready = 1'b0; seen = 1; break;
      end
      char_ready = char_valid;
      @(posedge clk); @(negedge clk);
    end
    chk("stall.reached_idx2", seen, 1);
    for (int c = 1; c <= 5; c++) begin
      start = (c == 2);
      @(posedge clk); @(negedge clk);
      chk($sformatf("stall.valid%0d", c), char_valid, 1);
      chk($sformatf("stall.char%0d", c), char_out, 3);
    end
    start = 1'b0; char_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("stall.bubble", char_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("stall.next_valid", char_valid, 1);
    chk("stall.next_char", char_out, 4);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin seen = 1; break; end
      @(posedge clk); @(negedge clk);
    end
    chk("stall.done_seen", seen, 1);
    @(posedge clk); @(negedge clk);
    chk("stall.busy_after", busy, 0);

    // Repeat playback with dwell 3: wraps to index 0, dwell+1 bubbles, never done
    repeat_en = 1'b1; dwell = 8'd3; len_string = 4'd5; start = 1'b1; char_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    k = 0; inv = 0; dn = 0;
    for (int c = 0; c < 300 && k < 12; c++) begin
      if (done) dn++;
      if (char_valid) begin
        if (k > 0) chk($sformatf("rep.gap%0d", k), inv, 4);
        inv = 0;
        chk($sformatf("rep.char%0d", k), char_out, base[k % 5]);
        chk($sformatf("rep.first%0d", k), first, (k % 5 == 0));
        k++;
      end else begin
        inv++;
      end
      @(posedge clk); @(negedge clk);
    end
    chk("rep.count", k, 12);
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    chk("rep.busy_after_abort", busy, 0);
    chk("rep.no_done", dn, 0);

    // Asynchronous reset while in GAP
    repeat_en = 1'b0; dwell = 8'd5; len_string = 4'd5; start = 1'b1; char_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (char_valid) begin seen = 1; break; end
      @(posedge clk); @(negedge clk);
    end
    chk("areset.first_valid", seen, 1);
    @(posedge clk); @(negedge clk);
    char_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("areset.in_gap_valid", char_valid, 0);
    chk("areset.in_gap_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("areset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 30; r++) run_random(r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
